yarp_dmem_resp: RTL
===================

Name: yarp_dmem_resp

Overview:
- Responder end of the core's data-memory request interface: a single-port, word-organised data SRAM model that services the load/store requests issued by the core's data-memory interface.
- Performs byte, half-word and word stores with per-lane write strobes.
- Returns load data right-justified after a parameterised pipelined latency.
- Flags misaligned, reserved-size and out-of-range accesses.
- Sits between the core's memory request port and the testbench/top-level; it is the memory the core talks to.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; address space 0 .. 4*DEPTH_WORDS-1.
- RD_LATENCY, 1, cycles from request to response for loads and stores; legal range 1..4. Elaboration error otherwise.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- data_mem_req_i  input  1  access request, one access per cycle when high
- data_mem_addr_i  input  32  byte address
- data_mem_byte_en_i  input  2  access size: 00 byte, 01 half-word, 11 word, 10 reserved
- data_mem_wr_i  input  1  1 = store, 0 = load
- data_mem_wr_data_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- mem_rd_data_o  output  32  load data, right-justified, unused upper bits zero
- mem_rsp_valid_o  output  1  single-cycle pulse RD_LATENCY cycles after each accepted request (load or store)
- mem_rsp_err_o  output  1  qualifies mem_rsp_valid_o; access was illegal and had no effect

Behaviour:
- Reset: mem_rd_data_o=0, mem_rsp_valid_o=0, mem_rsp_err_o=0; response pipeline cleared. Array contents are not reset.
- Requests are accepted every cycle with no backpressure. Responses are returned strictly in order.
- Word index = addr[31:2]. Lane offset = addr[1:0].
- Legality:
  - Byte: always aligned.
  - Half-word: requires addr[0]=0.
  - Word: requires addr[1:0]=00.
  - byte_en=10 is always illegal.
  - addr >= 4*DEPTH_WORDS is illegal.
  - An illegal access performs no write, returns rd_data 0 and raises err with its response.
- Store:
  - Write strobes are derived from size and offset: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes.
  - Data is shifted left by 8*addr[1:0].
  - The array is updated at the rising edge ending the request cycle.
  - Non-strobed lanes are unchanged.
  - The store response carries rd_data = 0.
- Load:
  - The array word is read at the request edge, shifted right by 8*addr[1:0], and masked to 8/16/32 bits.
  - The result is carried through a RD_LATENCY-deep pipeline together with valid and err.
- Read-after-write: a load issued the cycle after a store to the same word observes the stored data.
- Request with data_mem_req_i=0: no array access; a bubble (valid=0) enters the pipeline.
- Input values other than req are don't-care when req=0.
- Reset asserted mid-operation:
  - In-flight responses are discarded; outputs are 0 the cycle after reset is sampled low.
  - A store presented in a cycle where reset_n=0 is not performed.
- mem_rd_data_o holds its last value when valid=0 is not required; the bench checks data only when valid=1.

Decomposition:
- The access-size encoding (byte/half/word/reserved, 2-bit enum) lives in the shared yarp_pkg alongside the existing memory-access typedefs.
- Also in yarp_pkg: a response struct {valid, err, data[31:0]}.
- One sub-module, yarp_dmem_lane_ctrl (combinational): computes the write strobe, shifted write data, legality flag, and the load extract/mask function.
- The top module holds the array, write port and latency pipeline.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 (RD_LATENCY=1) -> one cycle later valid=1, err=0, rd_data=0xDEADBEEF.
- Byte store 0xAA @0x13, then loads:
  - word load @0x10 -> 0xAAADBEEF
  - byte load @0x13 -> 0x000000AA
  - half load @0x12 -> 0x0000AAAD
- Half load @0x11 -> response err=1, rd_data=0. Word store @0x12 -> err=1 and the word at 0x10 is unchanged. byte_en=10 -> err=1.
- Out-of-range: DEPTH_WORDS=1024, store @0x1000 -> err=1, no array change (word 0 is unchanged).
- RD_LATENCY=3, back-to-back loads @0x0, 0x4, 0x8 in consecutive cycles -> three consecutive valid pulses starting 3 cycles after the first request, with data in order.
- Loads in flight when reset_n is pulled low for one cycle -> no valid pulse emerges afterwards. A store presented in the reset cycle leaves memory unchanged.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared YARP memory-interface types: access-size encoding and the
// request/response records used by the data-memory path.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    RSVD_SZ   = 2'b10,
    WORD      = 2'b11
  } mem_access_size_e;

  typedef struct packed {
    logic              req;
    logic [31:0]       addr;
    mem_access_size_e  size;
    logic              wr;
    logic [31:0]       wr_data;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } mem_rsp_t;

  // Number of bytes touched by a legal access of the given size.
  function automatic logic [2:0] size_bytes(mem_access_size_e sz);
    case (sz)
      BYTE:      size_bytes = 3'd1;
      HALF_WORD: size_bytes = 3'd2;
      WORD:      size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/yarp_dmem_lane_ctrl.sv
// Byte-lane control for the data SRAM: legality, write strobes/alignment
// of store data, and right-justified extraction of load data.
module yarp_dmem_lane_ctrl
  import yarp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic [31:0]      addr_i,
  input  mem_access_size_e size_i,
  input  logic [31:0]      wr_data_i,
  input  logic [31:0]      rd_word_i,
  output logic             legal_o,
  output logic [3:0]       wr_strb_o,
  output logic [31:0]      wr_data_o,
  output logic [31:0]      rd_data_o
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [1:0]  off;
  logic [4:0]  sh;
  logic [31:0] rd_sh;
  logic        aligned;
  logic        in_range;

  assign off       = addr_i[1:0];
  assign sh        = {off, 3'b000};
  assign rd_sh     = rd_word_i >> sh;
  assign wr_data_o = wr_data_i << sh;
  assign in_range  = {1'b0, addr_i} < ADDR_LIMIT;
  assign legal_o   = aligned & in_range;

  // Reserved size falls through to the default: never aligned, no strobes.
  always_comb begin
    aligned   = 1'b0;
    wr_strb_o = 4'h0;
    rd_data_o = '0;
    case (size_i)
      BYTE: begin
        aligned   = 1'b1;
        wr_strb_o = 4'b0001 << off;
        rd_data_o = {24'h0, rd_sh[7:0]};
      end
      HALF_WORD: begin
        aligned   = ~off[0];
        wr_strb_o = 4'b0011 << {off[1], 1'b0};
        rd_data_o = {16'h0, rd_sh[15:0]};
      end
      WORD: begin
        aligned   = (off == 2'b00);
        wr_strb_o = 4'hF;
        rd_data_o = rd_sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/yarp_dmem_resp.sv
// Data-memory responder: word-organised SRAM with byte-lane stores and an
// in-order, fixed-latency response pipeline for loads and stores.
module yarp_dmem_resp
  import yarp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_rsp_valid_o,
  output logic        mem_rsp_err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("yarp_dmem_resp: RD_LATENCY must be in 1..4");
  end

  mem_access_size_e size;
  logic [AW-1:0]    widx;
  logic [31:0]      rd_word;
  logic             legal;
  logic [3:0]       wr_strb;
  logic [31:0]      wr_data_sh;
  logic [31:0]      rd_ext;
  logic             wr_en;

  logic [31:0] mem_q [DEPTH_WORDS];

  assign size    = mem_access_size_e'(data_mem_byte_en_i);
  assign widx    = data_mem_addr_i[AW+1:2];
  assign rd_word = mem_q[widx];

  yarp_dmem_lane_ctrl #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane_ctrl (
    .addr_i    (data_mem_addr_i),
    .size_i    (size),
    .wr_data_i (data_mem_wr_data_i),
    .rd_word_i (rd_word),
    .legal_o   (legal),
    .wr_strb_o (wr_strb),
    .wr_data_o (wr_data_sh),
    .rd_data_o (rd_ext)
  );

  // Array has no reset; a store in a reset cycle is suppressed here.
  assign wr_en = reset_n & data_mem_req_i & data_mem_wr_i & legal;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem_q[widx][8*b +: 8] <= wr_data_sh[8*b +: 8];
      end
    end
  end

  mem_rsp_t                  rsp_d;
  mem_rsp_t [RD_LATENCY-1:0] rsp_pipe_q;

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = data_mem_req_i;
    rsp_d.err   = data_mem_req_i & ~legal;
    rsp_d.data  = (data_mem_req_i & ~data_mem_wr_i & legal) ? rd_ext : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_pipe_q <= '0;
    end else begin
      rsp_pipe_q[0] <= rsp_d;
      for (int s = 1; s < int'(RD_LATENCY); s++) rsp_pipe_q[s] <= rsp_pipe_q[s-1];
    end
  end

  assign mem_rd_data_o   = rsp_pipe_q[RD_LATENCY-1].data;
  assign mem_rsp_valid_o = rsp_pipe_q[RD_LATENCY-1].valid;
  assign mem_rsp_err_o   = rsp_pipe_q[RD_LATENCY-1].err;

endmodule
